// File: rtl/alu_pkg.sv
// Shared ALU package: operation encodings used by the ALU control decoder
// and the multiply/divide sequencer, sequencer state codes and a helper
// that derives the iteration counter width from the operand width.
package alu_pkg;

  // ALU control operation encodings
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_DIV  = 3'b101;
  localparam logic [2:0] ALU_NOP  = 3'b110;
  localparam logic [2:0] ALU_MULT = 3'b111;

  // Sequencer states
  typedef logic [1:0] md_state_t;
  localparam md_state_t ST_IDLE = 2'b00;
  localparam md_state_t ST_CALC = 2'b01;
  localparam md_state_t ST_FIX  = 2'b10;

  // Width of a counter that walks 0..width-1 (at least one bit)
  function automatic int cnt_width(input int width);
    if (width > 2) begin
      return $clog2(width);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the control unit (master) and the
// multiply/divide sequencer (slave).
interface muldiv_if #(
  parameter int WIDTH = 32
);
  import alu_pkg::*;

  logic             start;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, alu_op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, alu_op, a, b,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the sequencer datapath.
//  MULT: accumulator is {partial product, remaining multiplier bits};
//        conditionally add the multiplicand to the upper half, then shift
//        right by one keeping the carry.
//  DIV : accumulator is {partial remainder, remaining dividend/quotient};
//        shift left by one, trial-subtract the divisor and restore on borrow.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] rem_s;
  logic [WIDTH:0] diff_s;

  // Single shift-add or restoring shift-subtract step
  always_comb begin
    sum_s  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} +
             (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    rem_s  = acc_i[2*WIDTH-1:WIDTH-1];
    diff_s = rem_s - {1'b0, opnd_i};
    if (is_div_i) begin
      if (!diff_s[WIDTH]) begin
        acc_o = {diff_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {rem_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum_s, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/DIV sequencer beside the single-cycle ALU.
// IDLE accepts one MULT or DIV, CALC runs WIDTH datapath iterations,
// FIX applies sign correction and writes HI/LO with a one-cycle done.
// Optional feature macro: MULDIV_SIGNED_EN (two's complement operands);
// when undefined the operands are unsigned and FIX writes the raw result.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  muldiv_if.slave  bus
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH-1);

  md_state_t          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               accept_s;
  logic               is_div_req_s;
  logic               b_zero_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [2*WIDTH-1:0] step_acc_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .acc_o    (step_acc_s)
  );

  // Request decode: only MULT/DIV in IDLE are accepted, everything else is dropped
  always_comb begin
    is_div_req_s = (bus.alu_op == ALU_DIV);
    b_zero_s     = (bus.b == {WIDTH{1'b0}});
    if ((state_q == ST_IDLE) && bus.start &&
        ((bus.alu_op == ALU_MULT) || (bus.alu_op == ALU_DIV))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

`ifdef MULDIV_SIGNED_EN
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic neg_hi_q, neg_hi_d;
  logic neg_lo_q, neg_lo_d;

  // Operand magnitudes for the unsigned datapath
  always_comb begin
    a_mag_s = bus.a[WIDTH-1] ? (~bus.a + ONE_W) : bus.a;
    b_mag_s = bus.b[WIDTH-1] ? (~bus.b + ONE_W) : bus.b;
  end

  // Result signs captured at accept: product/quotient from a^b, remainder from a
  always_comb begin
    neg_hi_d = neg_hi_q;
    neg_lo_d = neg_lo_q;
    if (accept_s) begin
      if (is_div_req_s && b_zero_s) begin
        neg_hi_d = 1'b0;
        neg_lo_d = 1'b0;
      end else if (is_div_req_s) begin
        neg_hi_d = bus.a[WIDTH-1];
        neg_lo_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      end else begin
        neg_hi_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        neg_lo_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      end
    end else begin
      neg_hi_d = neg_hi_q;
      neg_lo_d = neg_lo_q;
    end
  end

  // Sign flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
    end else begin
      neg_hi_q <= neg_hi_d;
      neg_lo_q <= neg_lo_d;
    end
  end

  // Sign correction: DIV negates halves independently, MULT the whole product
  always_comb begin
    logic [2*WIDTH-1:0] prod_v;
    prod_v = neg_hi_q ? (~acc_q + ONE_2W) : acc_q;
    if (is_div_q) begin
      fix_hi_s = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + ONE_W) : acc_q[2*WIDTH-1:WIDTH];
      fix_lo_s = neg_lo_q ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
    end else begin
      fix_hi_s = prod_v[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_v[WIDTH-1:0];
    end
  end
`else
  // Unsigned operands are their own magnitudes
  always_comb begin
    a_mag_s = bus.a;
    b_mag_s = bus.b;
  end

  // Unsigned result is written unchanged
  always_comb begin
    fix_hi_s = acc_q[2*WIDTH-1:WIDTH];
    fix_lo_s = acc_q[WIDTH-1:0];
  end
`endif

  // Sequencer next-state and datapath control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          busy_d     = 1'b1;
          cnt_d      = CNT_ZERO;
          is_div_d   = is_div_req_s;
          div_zero_d = 1'b0;
          if (is_div_req_s && b_zero_s) begin
            // Divide by zero skips the iterations with a fixed result
            state_d    = ST_FIX;
            div_zero_d = 1'b1;
            acc_d      = {bus.a, {WIDTH{1'b1}}};
            opnd_d     = {WIDTH{1'b0}};
          end else if (is_div_req_s) begin
            state_d = ST_CALC;
            acc_d   = {{WIDTH{1'b0}}, a_mag_s};
            opnd_d  = b_mag_s;
          end else begin
            state_d = ST_CALC;
            acc_d   = {{WIDTH{1'b0}}, b_mag_s};
            opnd_d  = a_mag_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d = step_acc_s;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_FIX;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ST_CALC;
        end
      end
      ST_FIX: begin
        hi_d    = fix_hi_s;
        lo_d    = fix_lo_s;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CW{1'b0}};
      acc_q      <= {(2*WIDTH){1'b0}};
      opnd_q     <= {WIDTH{1'b0}};
      is_div_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq (WIDTH=32). Expected values are hand
// computed; signed or unsigned expectations follow MULDIV_SIGNED_EN.
module tb_muldiv_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   edges;
  int   pulses;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; request is presented across exactly one rising edge
  task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    bus.start  = 1'b1;
    bus.alu_op = op;
    bus.a      = av;
    bus.b      = bv;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.alu_op = ALU_NOP;
  endtask

  // Called at a negedge with 'start_edges' rising edges counted since (and
  // including) the accepting edge; returns at the negedge where done is seen
  task automatic wait_done(input int start_edges, output int n);
    n = start_edges;
    while (bus.done !== 1'b1 && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.alu_op = ALU_NOP;
    bus.a      = 32'h0;
    bus.b      = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_dz",   {63'd0, bus.div_zero}, 64'd0);
    check("rst_hi",   {32'd0, bus.hi}, 64'd0);
    check("rst_lo",   {32'd0, bus.lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // MULT all-ones x all-ones
    issue(ALU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    check("mul1_busy", {63'd0, bus.busy}, 64'd1);
    wait_done(1, edges);
    check("mul1_lat", 64'(edges), 64'd34);
    check("mul1_busy_done", {63'd0, bus.busy}, 64'd0);
`ifdef MULDIV_SIGNED_EN
    check("mul1_hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_0001);
`else
    check("mul1_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
`endif
    @(negedge clk);
    check("mul1_done_1cyc", {63'd0, bus.done}, 64'd0);

    // DIV 0xFFFFFFF9 / 2  (-7 / 2 when signed)
    issue(ALU_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    @(negedge clk);
    wait_done(1, edges);
    check("div1_lat", 64'(edges), 64'd34);
`ifdef MULDIV_SIGNED_EN
    check("div1_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
    check("div1_hilo", {bus.hi, bus.lo}, 64'h0000_0001_7FFF_FFFC);
`endif
    @(negedge clk);

    // DIV 7 / 0xFFFFFFFE  (7 / -2 when signed)
    issue(ALU_DIV, 32'h0000_0007, 32'hFFFF_FFFE);
    @(negedge clk);
    wait_done(1, edges);
`ifdef MULDIV_SIGNED_EN
    check("div2_hilo", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFD);
`else
    check("div2_hilo", {bus.hi, bus.lo}, 64'h0000_0007_0000_0000);
`endif
    @(negedge clk);

    // Divide by zero: short path, sticky flag
    issue(ALU_DIV, 32'h0000_1234, 32'h0000_0000);
    @(negedge clk);
    wait_done(1, edges);
    check("dz_lat", 64'(edges), 64'd2);
    check("dz_flag", {63'd0, bus.div_zero}, 64'd1);
    check("dz_hilo", {bus.hi, bus.lo}, 64'h0000_1234_FFFF_FFFF);
    @(negedge clk);
    check("dz_sticky", {63'd0, bus.div_zero}, 64'd1);

    // MULT 3 x 5 clears div_zero; a re-issued start during CALC is ignored
    issue(ALU_MULT, 32'd3, 32'd5);
    @(negedge clk);
    check("dz_clear", {63'd0, bus.div_zero}, 64'd0);
    repeat (5) @(negedge clk);
    issue(ALU_DIV, 32'd100, 32'd7);
    @(negedge clk);
    check("reissue_busy", {63'd0, bus.busy}, 64'd1);
    wait_done(7, edges);
    check("reissue_lat", 64'(edges), 64'd34);
    check("reissue_hilo", {bus.hi, bus.lo}, 64'd15);

    // Back-to-back: start in the done cycle
    issue(ALU_MULT, 32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    check("b2b_busy", {63'd0, bus.busy}, 64'd1);
    check("b2b_hold", {bus.hi, bus.lo}, 64'd15);
    wait_done(1, edges);
    check("b2b_lat", 64'(edges), 64'd34);
    check("b2b_hilo", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
    @(negedge clk);

    // Most-negative / -1
    issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    @(negedge clk);
    wait_done(1, edges);
`ifdef MULDIV_SIGNED_EN
    check("minneg_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
`else
    check("minneg_hilo", {bus.hi, bus.lo}, 64'h8000_0000_0000_0000);
`endif
    @(negedge clk);

    // MULT 0xFFFFFFFD x 5  (-3 x 5 when signed)
    issue(ALU_MULT, 32'hFFFF_FFFD, 32'd5);
    @(negedge clk);
    wait_done(1, edges);
`ifdef MULDIV_SIGNED_EN
    check("mulneg_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
`else
    check("mulneg_hilo", {bus.hi, bus.lo}, 64'h0000_0004_FFFF_FFF1);
`endif
    @(negedge clk);

    // Reset around iteration 10 of a MULT
    issue(ALU_MULT, 32'h0000_1234, 32'h0000_5678);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_busy", {63'd0, bus.busy}, 64'd0);
    check("mrst_done", {63'd0, bus.done}, 64'd0);
    check("mrst_hilo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    check("mrst_no_done", 64'(pulses), 64'd0);

    // Non MULT/DIV op with start is ignored
    issue(ALU_ADD, 32'd5, 32'd6);
    @(negedge clk);
    check("add_busy", {63'd0, bus.busy}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    check("add_no_done", 64'(pulses), 64'd0);
    check("add_hilo", {bus.hi, bus.lo}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
